jt12_logsin: RTL

//  Reader/decoder side of the compressed phase-to-log-sine ROM used by the FM operator.

---
 rtl/jt12_logsin_pkg.sv | 61 ++++++
 rtl/jt12_logsin_dec.sv | 43 ++++
 rtl/jt12_logsin.sv | 130 +++++++++++++
 3 files changed

// File: rtl/jt12_logsin_pkg.sv
// jt12_logsin_pkg
//   Shared constants, types and helpers for the compressed log-sine ROM reader.
//
//   Compressed row format (46 bits, one row per rom_addr = p[5:1]).
//   A row holds the 8 values for p = {h[1:0], addr[4:0], l}.
//   For each quarter-wave group h the row stores:
//     B<h> : logsin of the odd entry (l=1), minus a per-group offset.
//     D<h> : difference even - odd. It is never negative because the
//            table decreases with p.
//   The field widths are set by the largest value / step each group can reach.
//     h  base range   offset  B width  max step  D width
//     0  ~357..~1731  256     11       ~406      9
//     1  ~129..~347   112     8        <=6       3
//     2  ~30..~126    0       7        <=3       2
//     3  0..~28       0       5        <=1       1
//   The widths add up to 11+9+8+3+7+2+5+1 = 46.
package jt12_logsin_pkg;

    localparam int LOGSIN_LAT = 3;
    localparam int LOGSIN_W   = 12;
    localparam int PHASE_W    = 10;
    localparam int ROM_AW     = 5;
    localparam int ROM_W      = 46;
    localparam int FOLD_W     = 8;

    // Row field layout: LSB position and width of each field.
    localparam int B0_LSB = 0;   localparam int B0_W = 11;
    localparam int D0_LSB = 11;  localparam int D0_W = 9;
    localparam int B1_LSB = 20;  localparam int B1_W = 8;
    localparam int D1_LSB = 28;  localparam int D1_W = 3;
    localparam int B2_LSB = 31;  localparam int B2_W = 7;
    localparam int D2_LSB = 38;  localparam int D2_W = 2;
    localparam int B3_LSB = 40;  localparam int B3_W = 5;
    localparam int D3_LSB = 45;  localparam int D3_W = 1;

    // Offsets that bring the two steep groups down into their narrow fields.
    localparam logic [LOGSIN_W-1:0] B0_OFS = 12'd256;
    localparam logic [LOGSIN_W-1:0] B1_OFS = 12'd112;

    // Folded phase: half-wave sign plus quarter-wave index.
    typedef struct packed {
        logic              sgn;
        logic [FOLD_W-1:0] p;
    } fold_t;

    // Stage-1 decode controls carried next to the ROM access.
    typedef struct packed {
        logic [1:0] hi;    // p[7:6]: quarter-wave group
        logic       lo;    // p[0]  : odd/even entry within the row
        logic       sgn;
    } s1_t;

    // Mirror the second quarter of each half-wave onto the first one.
    function automatic fold_t fold_phase(input logic [PHASE_W-1:0] phase);
        fold_t f;
        f.sgn = phase[9];
        f.p   = phase[8] ? ~phase[7:0] : phase[7:0];
        return f;
    endfunction

endpackage

// File: rtl/jt12_logsin_dec.sv
// jt12_logsin_dec
//   Purely combinational decoder for one compressed log-sine ROM row.
//   Ports:
//     row    in  ROM_W     compressed row returned by the phase ROM
//     sel    in  3         {p[7:6], p[0]} of the sample being decoded
//     logsin out LOGSIN_W  -log2(|sin|) in 4.8 fixed point
module jt12_logsin_dec
    import jt12_logsin_pkg::*;
(
    input  logic [ROM_W-1:0]    row,
    input  logic [2:0]          sel,
    output logic [LOGSIN_W-1:0] logsin
);

    logic [LOGSIN_W-1:0] base;
    logic [LOGSIN_W-1:0] delta;

    always_comb begin
        base  = '0;
        delta = '0;
        case (sel[2:1])
            2'd0: begin
                base  = LOGSIN_W'(row[B0_LSB +: B0_W]) + B0_OFS;
                delta = LOGSIN_W'(row[D0_LSB +: D0_W]);
            end
            2'd1: begin
                base  = LOGSIN_W'(row[B1_LSB +: B1_W]) + B1_OFS;
                delta = LOGSIN_W'(row[D1_LSB +: D1_W]);
            end
            2'd2: begin
                base  = LOGSIN_W'(row[B2_LSB +: B2_W]);
                delta = LOGSIN_W'(row[D2_LSB +: D2_W]);
            end
            default: begin
                base  = LOGSIN_W'(row[B3_LSB +: B3_W]);
                delta = LOGSIN_W'(row[D3_LSB +: D3_W]);
            end
        endcase
        // The base is the odd entry. The even entry sits one step earlier, so it is larger.
        logsin = sel[0] ? base : base + delta;
    end

endmodule

// File: rtl/jt12_logsin.sv
// jt12_logsin
//   Reader/decoder side of the compressed phase-to-log-sine ROM.
//   The block folds the operator phase to a quarter-wave index and drives the ROM row address.
//   It then decodes the returned row into a 12-bit log attenuation plus sign.
//   The pipeline has 3 stages, advanced by clk_en. Latency is 3 enabled edges.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     clk_en       pipeline advance strobe; all state holds when low
//     phase        [9]=half-wave sign, [8]=quarter mirror, [7:0]=index
//     slot_in      slot tag travelling with the phase
//     rom_addr     ROM row address (p[5:1]), straight from the stage-0 register
//     rom_data     registered ROM row (ROM samples rom_addr on clk_en)
//     logsin/sign  decoded result, registered
//     slot_out     slot tag aligned with logsin/sign
//   Optional: JT12_LOGSIN_VALID_EN adds valid_in/valid_out.
//     The valid bit travels with the data.
//     When valid_out is 0, sign is forced to 0.
module jt12_logsin
    import jt12_logsin_pkg::*;
#(
    parameter int ROM_W  = 46,
    parameter int SLOT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [PHASE_W-1:0]  phase,
    input  logic [SLOT_W-1:0]   slot_in,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [ROM_W-1:0]    rom_data,
    output logic [LOGSIN_W-1:0] logsin,
    output logic                sign,
`ifdef JT12_LOGSIN_VALID_EN
    input  logic                valid_in,
    output logic                valid_out,
`endif
    output logic [SLOT_W-1:0]   slot_out
);

    // Stage 0: folded phase and slot.
    fold_t               fold_q, fold_d;
    logic [SLOT_W-1:0]   slot0_q, slot0_d;
    // Stage 1: decode controls aligned with the row the ROM is returning.
    s1_t                 s1_q, s1_d;
    logic [SLOT_W-1:0]   slot1_q, slot1_d;
    // Stage 2: output registers.
    logic [LOGSIN_W-1:0] logsin_q, logsin_d;
    logic                sign_q, sign_d;
    logic [SLOT_W-1:0]   slot_out_q, slot_out_d;

    // Fill tracker: bit i is set once stage i holds a real sample after reset.
    // The ROM output register is not reset, so during the first two enabled edges
    // it still holds a stale row. The output is forced to 0 until stage 1 is live.
    logic [LOGSIN_LAT-2:0] vld_pipe_q, vld_pipe_d;

`ifdef JT12_LOGSIN_VALID_EN
    logic [LOGSIN_LAT-1:0] val_pipe_q, val_pipe_d;
`endif

    logic [LOGSIN_W-1:0] dec_logsin;

    jt12_logsin_dec u_dec (
        .row    (rom_data),
        .sel    ({s1_q.hi, s1_q.lo}),
        .logsin (dec_logsin)
    );

    always_comb begin
        fold_d     = fold_phase(phase);
        slot0_d    = slot_in;

        s1_d.hi    = fold_q.p[7:6];
        s1_d.lo    = fold_q.p[0];
        s1_d.sgn   = fold_q.sgn;
        slot1_d    = slot0_q;

        vld_pipe_d = {vld_pipe_q[LOGSIN_LAT-3:0], 1'b1};

        logsin_d   = '0;
        sign_d     = 1'b0;
        slot_out_d = '0;
        if (vld_pipe_q[LOGSIN_LAT-2]) begin
            logsin_d   = dec_logsin;
            sign_d     = s1_q.sgn;
            slot_out_d = slot1_q;
        end

`ifdef JT12_LOGSIN_VALID_EN
        val_pipe_d = {val_pipe_q[LOGSIN_LAT-2:0], valid_in};
        sign_d     = sign_d & val_pipe_q[LOGSIN_LAT-2];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fold_q     <= '0;
            slot0_q    <= '0;
            s1_q       <= '0;
            slot1_q    <= '0;
            logsin_q   <= '0;
            sign_q     <= 1'b0;
            slot_out_q <= '0;
            vld_pipe_q <= '0;
`ifdef JT12_LOGSIN_VALID_EN
            val_pipe_q <= '0;
`endif
        end else if (clk_en) begin
            fold_q     <= fold_d;
            slot0_q    <= slot0_d;
            s1_q       <= s1_d;
            slot1_q    <= slot1_d;
            logsin_q   <= logsin_d;
            sign_q     <= sign_d;
            slot_out_q <= slot_out_d;
            vld_pipe_q <= vld_pipe_d;
`ifdef JT12_LOGSIN_VALID_EN
            val_pipe_q <= val_pipe_d;
`endif
        end
    end

    assign rom_addr  = fold_q.p[5:1];
    assign logsin    = logsin_q;
    assign sign      = sign_q;
    assign slot_out  = slot_out_q;
`ifdef JT12_LOGSIN_VALID_EN
    assign valid_out = val_pipe_q[LOGSIN_LAT-1];
`endif

endmodule
